// File: rtl/window_scan_ctrl.sv
// Fill/scan sequencer for the padded 3x3 window memory of one strip.
// Optional WSC_STALL_CNT_EN adds a saturating downstream-stall cycle counter.
module window_scan_ctrl #(
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned PAD_W      = 258,
    parameter int unsigned STRIP_ROWS = 32,
    parameter int unsigned AW         = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_base,
    output logic          win_valid,
    input  logic          win_ready,
    output logic          busy,
    output logic          done
`ifdef WSC_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int unsigned DEPTH = PAD_W * (STRIP_ROWS + 2);
    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (STRIP_ROWS > 1) ? $clog2(STRIP_ROWS) : 1;

    localparam logic [AW-1:0] LAST_WADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(PAD_W);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(STRIP_ROWS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          win_valid_q, win_valid_d;
    logic [AW-1:0] next_addr;
    logic          stall;
`ifdef WSC_STALL_CNT_EN
    logic [15:0]   stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        out_addr_d = out_addr_q;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_base    = '0;
        next_addr  = row_base_q + AW'(col_q);
        stall      = win_valid_q & ~win_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FILL;
                    wcnt_d     = '0;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                    out_addr_d = '0;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (in_valid) begin
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == LAST_WADDR) state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                rd_en = 1'b1;
                // A stalled window is re-read from out_addr so the taps keep presenting it.
                if (stall) begin
                    rd_base = out_addr_q;
                end else begin
                    rd_base    = next_addr;
                    out_addr_d = next_addr;
                    if (col_q == COL_LAST) begin
                        col_d      = '0;
                        row_d      = row_q + RW'(1);
                        row_base_d = row_base_q + ROW_STEP;
                        if (row_q == ROW_LAST) state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (stall) begin
                    rd_en   = 1'b1;
                    rd_base = out_addr_q;
                end else if (win_valid_q && win_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        win_valid_d = rd_en;
    end

`ifdef WSC_STALL_CNT_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            out_addr_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            out_addr_q  <= out_addr_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign wr_addr   = wcnt_q;
    assign win_valid = win_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: fill, raster scan, stalls, reset abort.
module tb_window_scan_ctrl;

    localparam int AW        = 14;
    localparam int DEPTH     = 8772;
    localparam int NWIN      = 8192;
    localparam int HOLD_ADDR = 302;   // window 300: row 1, col 44 -> 258 + 44
    localparam int LAST_BASE = 8253;  // row 31, col 255 -> 31*258 + 255

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, win_ready;
    logic          in_ready, wr_en, rd_en, win_valid, busy, done;
    logic [AW-1:0] wr_addr, rd_base;
`ifdef WSC_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    window_scan_ctrl #(.IMG_W(256), .PAD_W(258), .STRIP_ROWS(32), .AW(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_base   (rd_base),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .busy      (busy),
        .done      (done)
`ifdef WSC_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int wr_cnt, wr_exp, wr_err, first_wr_addr, first_wr_cyc, last_wr_cyc;
    int win_cnt, win_err, vld_err, stall_err, stall_cyc, hold_cnt, last_cons;
    int done_cnt, done_cyc, busy_at_done;
    int ready_after, rden_after, chk_next;
    int prev_rd_en, prev_base;
    int stall_left;

    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int exp_addr(input int k);
        return (k / 256) * 258 + (k % 256);
    endfunction

    task automatic clr();
        wr_cnt = 0; wr_exp = 0; wr_err = 0; first_wr_addr = -1;
        first_wr_cyc = -1; last_wr_cyc = -1;
        win_cnt = 0; win_err = 0; vld_err = 0; stall_err = 0;
        stall_cyc = 0; hold_cnt = 0; last_cons = -1;
        done_cnt = 0; done_cyc = -1; busy_at_done = 0;
        ready_after = 1; rden_after = 0; chk_next = 0;
        prev_rd_en = 0; prev_base = 0;
    endtask

    // Observe one cycle with inputs already applied, then advance past the edge.
    task automatic tick();
        #3;
        cyc++;
        if (wr_en) begin
            if (int'(wr_addr) != wr_exp) wr_err++;
            if (wr_cnt == 0) begin
                first_wr_addr = int'(wr_addr);
                first_wr_cyc  = cyc;
            end
            wr_exp++;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (chk_next != 0) begin
            ready_after = int'(in_ready);
            rden_after  = int'(rd_en);
            chk_next    = 0;
        end
        if (wr_en && int'(wr_addr) == DEPTH - 1) chk_next = 1;
        if (int'(win_valid) != prev_rd_en) vld_err++;
        if (win_valid && win_ready) begin
            if (prev_base != exp_addr(win_cnt)) win_err++;
            last_cons = prev_base;
            win_cnt++;
        end
        if (win_valid && !win_ready) begin
            stall_cyc++;
            if (!rd_en || int'(rd_base) != prev_base) stall_err++;
            if (rd_en && int'(rd_base) == HOLD_ADDR) hold_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = int'(busy);
        end
        prev_rd_en = int'(rd_en & rst_n);
        prev_base  = int'(rd_base);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        clr();
        @(posedge clk); #1;
        tick();
        tick();
        rst_n = 1'b1; in_valid = 1'b1;
        #1;
        check("rst_in_ready",  int'(in_ready),  0);
        check("rst_wr_en",     int'(wr_en),     0);
        check("rst_rd_en",     int'(rd_en),     0);
        check("rst_win_valid", int'(win_valid), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_wr_addr",   int'(wr_addr),   0);
        check("rst_rd_base",   int'(rd_base),   0);
`ifdef WSC_STALL_CNT_EN
        check("rst_stall_cnt", int'(stall_cnt), 0);
`endif

        // Strip A: continuous pixels, downstream always ready
        clr();
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
        #1;
        check("a_writes",       wr_cnt,                    DEPTH);
        check("a_wr_addr_err",  wr_err,                    0);
        check("a_first_wr",     first_wr_addr,             0);
        check("a_ready_drop",   ready_after,               0);
        check("a_scan_entry",   rden_after,                1);
        check("a_windows",      win_cnt,                   NWIN);
        check("a_order_err",    win_err,                   0);
        check("a_valid_err",    vld_err,                   0);
        check("a_last_base",    last_cons,                 LAST_BASE);
        check("a_done_pulses",  done_cnt,                  1);
        check("a_done_latency", done_cyc - last_wr_cyc,    NWIN + 2);
        check("a_busy_at_done", busy_at_done,              1);
        check("a_busy_after",   int'(busy),                0);
        check("a_done_after",   int'(done),                0);

        // Strip B: pixel gaps every other cycle, stray start, stall at window 300
        clr();
        stall_left = 3;
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
            in_valid = ~in_valid;
            start    = (wr_cnt == 4000);
            if (win_valid && win_cnt == 300 && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = 1'b1;
            end
            tick();
        end
        start = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
        check("b_writes",      wr_cnt,                          DEPTH);
        check("b_wr_addr_err", wr_err,                          0);
        check("b_fill_span",   last_wr_cyc - first_wr_cyc + 1, 17543);
        check("b_hold_reissue", hold_cnt,                       3);
        check("b_stall_cycles", stall_cyc,                      3);
        check("b_stall_err",   stall_err,                       0);
        check("b_windows",     win_cnt,                         NWIN);
        check("b_order_err",   win_err,                         0);
        check("b_valid_err",   vld_err,                         0);
        check("b_done_pulses", done_cnt,                        1);

        // Strip C: reset while scanning at window 1000
        clr();
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20000 && win_cnt < 1000; i++) tick();
        check("c_reach", win_cnt, 1000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("c_in_ready",  int'(in_ready),  0);
        check("c_wr_en",     int'(wr_en),     0);
        check("c_rd_en",     int'(rd_en),     0);
        check("c_win_valid", int'(win_valid), 0);
        check("c_busy",      int'(busy),      0);
        check("c_done",      int'(done),      0);
        check("c_wr_addr",   int'(wr_addr),   0);
        check("c_rd_base",   int'(rd_base),   0);
        check("c_no_done",   done_cnt,        0);

        // Strip D: refill after abort, random downstream backpressure
        clr();
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
            win_ready = 1'($urandom_range(0, 1));
            tick();
        end
        win_ready = 1'b1;
        #1;
        check("d_first_wr",    first_wr_addr, 0);
        check("d_writes",      wr_cnt,        DEPTH);
        check("d_wr_addr_err", wr_err,        0);
        check("d_windows",     win_cnt,       NWIN);
        check("d_order_err",   win_err,       0);
        check("d_valid_err",   vld_err,       0);
        check("d_stall_err",   stall_err,     0);
        check("d_last_base",   last_cons,     LAST_BASE);
        check("d_done_pulses", done_cnt,      1);
`ifdef WSC_STALL_CNT_EN
        check("d_stall_cnt",   int'(stall_cnt), stall_cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("d_stall_clear", int'(stall_cnt), 0);
        check("d_busy_fill",   int'(in_ready),  1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
